// File: rtl/picmicro_pkg.sv
// Shared definitions for the PIC16 midrange instruction-cycle sequencer.
// QSEQ_IRQ_EN adds the interrupt-entry cycle state.
package picmicro_pkg;

  typedef enum logic [2:0] {
    ST_FILL       = 3'd0,
    ST_EXEC       = 3'd1,
    ST_FLUSH_LD   = 3'd2,
    ST_FLUSH_SKIP = 3'd3,
`ifdef QSEQ_IRQ_EN
    ST_IRQ        = 3'd4,
`endif
    ST_SLEEP      = 3'd5
  } cyc_state_e;

  localparam logic [1:0] Q1 = 2'd0;
  localparam logic [1:0] Q2 = 2'd1;
  localparam logic [1:0] Q3 = 2'd2;
  localparam logic [1:0] Q4 = 2'd3;

  localparam logic [12:0] IRQ_VECTOR = 13'h004;

  // Cycles that load the instruction register at Q4.
  function automatic logic state_fetches(input cyc_state_e s);
    logic v;
    case (s)
      ST_FILL, ST_EXEC, ST_FLUSH_LD, ST_FLUSH_SKIP: v = 1'b1;
      default:                                      v = 1'b0;
    endcase
    return v;
  endfunction

  // Cycles that advance the PC at Q1.
  function automatic logic state_increments(input cyc_state_e s);
    logic v;
    case (s)
      ST_EXEC, ST_FLUSH_SKIP: v = 1'b1;
      default:                v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/qcycle_sequencer_qphase_counter.sv
// Two-bit Q1..Q4 phase counter with synchronous reset and hold; also exports
// the next phase so the sequencer can register its strobes.
module qphase_counter
  import picmicro_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hold,
  output logic [1:0] o_q_phase,
  output logic [1:0] o_q_nxt,
  output logic       o_is_q1,
  output logic       o_is_q3,
  output logic       o_is_q4
);

  logic [1:0] r_q;
  logic [1:0] w_q_nxt;

  // Next phase: reset to Q1, freeze on hold, otherwise wrap.
  always_comb begin
    w_q_nxt = r_q;
    if (rst) begin
      w_q_nxt = Q1;
    end else if (i_hold) begin
      w_q_nxt = r_q;
    end else begin
      w_q_nxt = r_q + 2'd1;
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= Q1;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign o_q_phase = r_q;
  assign o_q_nxt   = w_q_nxt;
  assign o_is_q1   = (r_q == Q1);
  assign o_is_q3   = (r_q == Q3);
  assign o_is_q4   = (r_q == Q4);

endmodule

// File: rtl/qcycle_sequencer.sv
// PIC16 instruction-cycle sequencer: Q-phase timing, forced-NOP cycles, SLEEP/wake.
// Define QSEQ_IRQ_EN to enable the interrupt-entry cycle and irq_vector_en.
module qcycle_sequencer
  import picmicro_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       branch_taken,
  input  logic       skip_taken,
  input  logic       sleep_req,
  input  logic       irq_req,
  input  logic       wake_req,
  output logic [1:0] q_phase,
  output logic       incr_pc_en,
  output logic       instr_rd_en,
  output logic       exec_valid,
  output logic       exec_wr_en,
  output logic       irq_vector_en,
  output logic       sleeping
);

  cyc_state_e r_state;
  cyc_state_e w_state_nxt;
  logic [1:0] w_q_nxt;
  logic       w_hold;
  logic       w_unused_q1;
  logic       w_is_q3;
  logic       w_is_q4;
  logic       r_branch;
  logic       r_skip;
  logic       r_sleep;
  logic       r_incr_pc_en;
  logic       r_instr_rd_en;
  logic       r_exec_valid;
  logic       r_exec_wr_en;
  logic       r_irq_vector_en;
  logic       r_sleeping;

  assign w_hold = (r_state == ST_SLEEP) && !wake_req;

  qphase_counter u_qphase (
    .clk       (clk),
    .rst       (rst),
    .i_hold    (w_hold),
    .o_q_phase (q_phase),
    .o_q_nxt   (w_q_nxt),
    .o_is_q1   (w_unused_q1),
    .o_is_q3   (w_is_q3),
    .o_is_q4   (w_is_q4)
  );

`ifndef QSEQ_IRQ_EN
  logic w_unused_irq;
  assign w_unused_irq = irq_req;
`endif

  // Cycle-state decision: taken on the Q4->Q1 edge, or on any clock while asleep.
  always_comb begin
    w_state_nxt = r_state;
    if (rst) begin
      w_state_nxt = ST_FILL;
    end else if (r_state == ST_SLEEP) begin
      if (wake_req) begin
        w_state_nxt = ST_EXEC;
      end else begin
        w_state_nxt = ST_SLEEP;
      end
    end else if (w_is_q4) begin
      case (r_state)
        ST_EXEC: begin
          if (r_sleep) begin
            w_state_nxt = ST_SLEEP;
          end else if (r_branch) begin
            w_state_nxt = ST_FLUSH_LD;
          end else if (r_skip) begin
            w_state_nxt = ST_FLUSH_SKIP;
`ifdef QSEQ_IRQ_EN
          end else if (irq_req) begin
            w_state_nxt = ST_IRQ;
`endif
          end else begin
            w_state_nxt = ST_EXEC;
          end
        end
`ifdef QSEQ_IRQ_EN
        ST_IRQ:                       w_state_nxt = ST_FLUSH_LD;
`endif
        ST_FILL, ST_FLUSH_LD,
        ST_FLUSH_SKIP:                w_state_nxt = ST_EXEC;
        default:                      w_state_nxt = ST_FILL;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, Q3 request capture and strobes registered from the upcoming state/phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_FILL;
      r_branch        <= 1'b0;
      r_skip          <= 1'b0;
      r_sleep         <= 1'b0;
      r_incr_pc_en    <= 1'b0;
      r_instr_rd_en   <= 1'b0;
      r_exec_valid    <= 1'b0;
      r_exec_wr_en    <= 1'b0;
      r_irq_vector_en <= 1'b0;
      r_sleeping      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_is_q3) begin
        r_branch <= branch_taken;
        r_skip   <= skip_taken;
        r_sleep  <= sleep_req;
      end
      r_incr_pc_en  <= state_increments(w_state_nxt) && (w_q_nxt == Q1);
      r_instr_rd_en <= state_fetches(w_state_nxt) && (w_q_nxt == Q4);
      r_exec_valid  <= (w_state_nxt == ST_EXEC);
      r_exec_wr_en  <= (w_state_nxt == ST_EXEC) && (w_q_nxt == Q4);
`ifdef QSEQ_IRQ_EN
      r_irq_vector_en <= (w_state_nxt == ST_IRQ) && (w_q_nxt == Q4);
`else
      r_irq_vector_en <= 1'b0;
`endif
      r_sleeping    <= (w_state_nxt == ST_SLEEP);
    end
  end

  assign incr_pc_en    = r_incr_pc_en;
  assign instr_rd_en   = r_instr_rd_en;
  assign exec_valid    = r_exec_valid;
  assign exec_wr_en    = r_exec_wr_en;
  assign irq_vector_en = r_irq_vector_en;
  assign sleeping      = r_sleeping;

endmodule

// File: tb/tb_qcycle_sequencer.sv
// Scoreboard bench for qcycle_sequencer: a cycle-kind reference model predicts
// every clock's outputs, a monitor compares them one clock at a time.
module tb_qcycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       branch_taken = 1'b0;
  logic       skip_taken = 1'b0;
  logic       sleep_req = 1'b0;
  logic       irq_req = 1'b0;
  logic       wake_req = 1'b0;
  logic [1:0] q_phase;
  logic       incr_pc_en;
  logic       instr_rd_en;
  logic       exec_valid;
  logic       exec_wr_en;
  logic       irq_vector_en;
  logic       sleeping;

  qcycle_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .skip_taken    (skip_taken),
    .sleep_req     (sleep_req),
    .irq_req       (irq_req),
    .wake_req      (wake_req),
    .q_phase       (q_phase),
    .incr_pc_en    (incr_pc_en),
    .instr_rd_en   (instr_rd_en),
    .exec_valid    (exec_valid),
    .exec_wr_en    (exec_wr_en),
    .irq_vector_en (irq_vector_en),
    .sleeping      (sleeping)
  );

  always #5 clk = ~clk;

`ifdef QSEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef enum int {K_FILL, K_EXEC, K_FLD, K_FSKIP, K_IRQ, K_SLEEP} kind_t;

  kind_t      m_kind = K_FILL;
  int         m_pos = 0;
  bit         m_b = 1'b0;
  bit         m_s = 1'b0;
  bit         m_sl = 1'b0;
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         seen_irqv = 0;

  // Per-kind strobe patterns: bit n set means the strobe fires in phase Qn+1.
  function automatic logic [7:0] expect_vec(input kind_t k, input int pos);
    logic [3:0] incr_m, rd_m, wr_m, irqv_m;
    logic       valid, slp;
    incr_m = 4'b0000; rd_m = 4'b0000; wr_m = 4'b0000; irqv_m = 4'b0000;
    valid = 1'b0; slp = 1'b0;
    case (k)
      K_FILL:  rd_m = 4'b1000;
      K_EXEC:  begin incr_m = 4'b0001; rd_m = 4'b1000; wr_m = 4'b1000; valid = 1'b1; end
      K_FLD:   rd_m = 4'b1000;
      K_FSKIP: begin incr_m = 4'b0001; rd_m = 4'b1000; end
      K_IRQ:   irqv_m = 4'b1000;
      default: slp = 1'b1;
    endcase
    return {pos[1:0], incr_m[pos], rd_m[pos], valid, wr_m[pos], irqv_m[pos], slp};
  endfunction

  task automatic model_step(input bit r, input bit b, input bit s, input bit sl,
                            input bit iq, input bit wk);
    if (r) begin
      m_kind = K_FILL;
      m_pos  = 0;
    end else if (m_kind == K_SLEEP) begin
      if (wk) begin
        m_kind = K_EXEC;
        m_pos  = 1;
      end
    end else if (m_pos == 3) begin
      m_pos = 0;
      case (m_kind)
        K_EXEC:  m_kind = m_sl ? K_SLEEP : m_b ? K_FLD : m_s ? K_FSKIP :
                          (IRQ_ON && iq) ? K_IRQ : K_EXEC;
        K_IRQ:   m_kind = K_FLD;
        default: m_kind = K_EXEC;
      endcase
    end else begin
      if (m_pos == 2) begin
        m_b  = b;
        m_s  = s;
        m_sl = sl;
      end
      m_pos = m_pos + 1;
    end
  endtask

  task automatic drive(input bit r, input bit b, input bit s, input bit sl,
                       input bit iq, input bit wk);
    rst = r; branch_taken = b; skip_taken = s; sleep_req = sl; irq_req = iq; wake_req = wk;
    model_step(r, b, s, sl, iq, wk);
    exp_q.push_back(expect_vec(m_kind, m_pos));
    @(negedge clk);
  endtask

  task automatic quiet_until(input kind_t k, input int pos, input string what);
    int n;
    n = 0;
    while (!(m_kind == k && m_pos == pos) && n < 64) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!(m_kind == k && m_pos == pos)) begin
      errors++;
      $display("FAIL wait_%s: target cycle not reached within 64 clocks", what);
    end
  endtask

  // Monitor: one prediction per clock, compared 1 time unit after the edge.
  initial begin
    logic [7:0] act;
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      #1;
      act = {q_phase, incr_pc_en, instr_rd_en, exec_valid, exec_wr_en, irq_vector_en, sleeping};
      if (irq_vector_en === 1'b1) seen_irqv++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs @%0t: got {q,incr,rd,valid,wr,irqv,slp}=%b_%b%b%b%b%b%b want %b_%b%b%b%b%b%b",
                   $time, act[7:6], act[5], act[4], act[3], act[2], act[1], act[0],
                   exp[7:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    // Reset, then quiet FILL/EXEC start-up.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch, then skip, each raised only at Q3.
    quiet_until(K_EXEC, 2, "branch");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet_until(K_EXEC, 2, "skip");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Interrupt alone, then together with a branch.
    quiet_until(K_EXEC, 3, "irq");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet_until(K_EXEC, 2, "irq_br");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // SLEEP held 20+ clocks, wake_req ignored before, then wake.
    quiet_until(K_EXEC, 2, "sleep");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (24) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted at Q3 of a skip-flush cycle.
    quiet_until(K_EXEC, 2, "skip2");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet_until(K_FSKIP, 2, "rst_mid");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 300) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
            ($urandom % 20) == 0, ($urandom % 3) == 0, ($urandom % 6) == 0);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    if (!IRQ_ON) begin
      checks++;
      if (seen_irqv != 0) begin
        errors++;
        $display("FAIL irqv_disabled: irq_vector_en seen %0d times, want 0", seen_irqv);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
